// File: rtl/frog_hop_requester.sv
// Turns four raw push-buttons into paced, single-hop active-low direction requests for the frog mover.
// Synchroniser + debounce per button, priority arbitration, one-deep buffer during the hop cooldown.
module frog_hop_requester #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18,
   parameter int HOP_FRAMES      = 12,
   parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ani_stb,
   input  logic i_animate,
   input  logic i_dead,
   input  logic i_btn_up,
   input  logic i_btn_down,
   input  logic i_btn_left,
   input  logic i_btn_right,
   output logic o_up_n,
   output logic o_down_n,
   output logic o_left_n,
   output logic o_right_n,
   output logic o_busy,
   output logic o_drop
);
   localparam int               HOP_W    = $clog2(HOP_FRAMES + 1);
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOP_W-1:0] HOP_LAST = HOP_W'(HOP_FRAMES - 1);
   localparam logic [3:0]       RAW_REL  = BTN_ACTIVE_HIGH ? 4'b0000 : 4'b1111;

   typedef enum logic [1:0] {IDLE, PENDING, COOLDOWN} state_t;

   // Bit order everywhere: [3]=up, [2]=down, [1]=left, [0]=right
   logic [3:0]       w_raw;
   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [3:0]       w_synced;
   logic [3:0]       r_stable;
   logic [3:0]       r_stable_d;
   logic [CNT_W-1:0] r_dcnt [4];
   logic [3:0]       w_evt;
   logic [3:0]       w_win;
   logic             w_any;
   logic             w_multi;
   logic             w_stb;

   state_t           r_state;
   logic [HOP_W-1:0] r_cnt;
   logic [3:0]       r_buf;
   logic             r_buf_vld;
   logic [3:0]       r_req_n;
   logic             r_busy;
   logic             r_drop;

   assign w_raw    = {i_btn_up, i_btn_down, i_btn_left, i_btn_right};
   assign w_synced = BTN_ACTIVE_HIGH ? r_sync2 : ~r_sync2;
   assign w_evt    = r_stable & ~r_stable_d;
   assign w_any    = |w_evt;
   assign w_multi  = |(w_evt & ~w_win);
   assign w_stb    = i_ani_stb & i_animate;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1    <= RAW_REL;
         r_sync2    <= RAW_REL;
         r_stable_d <= 4'b0000;
      end else begin
         r_sync1    <= w_raw;
         r_sync2    <= r_sync1;
         r_stable_d <= r_stable;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stable <= 4'b0000;
         for (int i = 0; i < 4; i++) r_dcnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_synced[i] == r_stable[i]) begin
               r_dcnt[i] <= '0;
            end else if (r_dcnt[i] == DB_LAST) begin
               r_stable[i] <= w_synced[i];
               r_dcnt[i]   <= '0;
            end else begin
               r_dcnt[i] <= r_dcnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_win = 4'b0000;
      if (w_evt[3])      w_win = 4'b1000;
      else if (w_evt[2]) w_win = 4'b0100;
      else if (w_evt[1]) w_win = 4'b0010;
      else if (w_evt[0]) w_win = 4'b0001;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_buf     <= 4'b0000;
         r_buf_vld <= 1'b0;
         r_req_n   <= 4'b1111;
         r_busy    <= 1'b0;
         r_drop    <= 1'b0;
      end else if (i_dead) begin
         // Death discards same-cycle events silently; debounce keeps its state
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_buf     <= 4'b0000;
         r_buf_vld <= 1'b0;
         r_req_n   <= 4'b1111;
         r_busy    <= 1'b0;
         r_drop    <= 1'b0;
      end else begin
         r_drop <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state <= PENDING;
                  r_req_n <= ~w_win;
                  r_busy  <= 1'b1;
                  r_drop  <= w_multi;
               end
            end
            PENDING: begin
               r_drop <= w_any;
               if (w_stb) begin
                  r_state <= COOLDOWN;
                  r_cnt   <= '0;
                  r_req_n <= 4'b1111;
               end
            end
            COOLDOWN: begin
               if (w_any) r_drop <= r_buf_vld | w_multi;
               if (w_stb && r_cnt == HOP_LAST) begin
                  if (r_buf_vld) begin
                     r_state   <= PENDING;
                     r_req_n   <= ~r_buf;
                     r_buf     <= 4'b0000;
                     r_buf_vld <= 1'b0;
                  end else if (w_any) begin
                     // Event landing on the final strobe goes straight through the empty buffer
                     r_state <= PENDING;
                     r_req_n <= ~w_win;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  if (w_stb) r_cnt <= r_cnt + 1'b1;
                  if (w_any && !r_buf_vld) begin
                     r_buf     <= w_win;
                     r_buf_vld <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_req_n <= 4'b1111;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_up_n    = r_req_n[3];
   assign o_down_n  = r_req_n[2];
   assign o_left_n  = r_req_n[1];
   assign o_right_n = r_req_n[0];
   assign o_busy    = r_busy;
   assign o_drop    = r_drop;

endmodule
